// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, guard-band words, TERC4 table and bit helpers.
// The TERC4 and guard-band items are only consumed when TMDS_TERC4_EN is defined.
package tmds_pkg;

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] CTRL_01  = 10'b0010101011;
    localparam logic [9:0] CTRL_10  = 10'b0101010100;
    localparam logic [9:0] CTRL_11  = 10'b1010101011;

    localparam logic [9:0] GB_VID_0 = 10'b1011001100;
    localparam logic [9:0] GB_VID_1 = 10'b0100110011;

    // Sideband fields that travel with a symbol through the first pipeline stage.
    typedef struct packed {
        logic       de;
        logic [1:0] c;
        logic       aux_en;
        logic [3:0] aux;
        logic       guard;
    } side_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

    function automatic logic [9:0] terc4(input logic [3:0] nib);
        case (nib)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++)
            n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// First TMDS pipeline stage: transition-minimising XOR/XNOR chain, registered q_m and its ones count.
// Sideband (DE, C, AUX_EN, AUX, GUARD) is registered alongside so stage two sees a coherent symbol.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic       aux_en,
    input  logic [3:0] aux,
    input  logic       guard,
    output logic [8:0] q_m,
    output logic [3:0] n1,
    output side_t      side
);

    logic       use_xnor;
    logic [3:0] d_ones;
    logic [8:0] q_m_next;

    always_comb begin
        // NOTE: every variable gets a value before any branch or loop so no latch can be inferred.
        d_ones   = popcount8(d);
        use_xnor = (d_ones > 4'd4) || (d_ones == 4'd4 && !d[0]);
        q_m_next = '0;
        q_m_next[0] = d[0];
        for (int i = 1; i < 8; i++)
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ d[i]) : (q_m_next[i-1] ^ d[i]);
        q_m_next[8] = ~use_xnor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m  <= '0;
            n1   <= '0;
            side <= '{de: 1'b0, c: 2'b00, aux_en: 1'b0, aux: 4'h0, guard: 1'b0};
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            q_m  <= q_m_next;
            n1   <= popcount8(q_m_next[7:0]);
            side <= '{de: de, c: c, aux_en: aux_en, aux: aux, guard: guard};
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: stage-1 q_m, stage-2 DC balance with running disparity, output mux.
// Define TMDS_TERC4_EN to enable guard-band and TERC4 data-island symbols (AUX_EN, AUX, GUARD).
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int CNT_W   = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DE,
    input  logic [7:0] D,
    input  logic [1:0] C,
    input  logic       AUX_EN,
    input  logic [3:0] AUX,
    input  logic       GUARD,
    output logic [9:0] Q
);

    localparam logic signed [CNT_W-1:0] ZERO = '0;
    localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);

    logic [8:0] q_m;
    logic [3:0] n1;
    side_t      s1;

    tmds_qm_stage u_qm (
        .clk    (CLK),
        .rst    (RST),
        .de     (DE),
        .d      (D),
        .c      (C),
        .aux_en (AUX_EN),
        .aux    (AUX),
        .guard  (GUARD),
        .q_m    (q_m),
        .n1     (n1),
        .side   (s1)
    );

    logic signed [CNT_W-1:0] cnt, cnt_next, data_cnt;
    logic signed [CNT_W-1:0] n1_s, n0_s, diff, qm8_two, nqm8_two;
    logic                    cnt_pos, cnt_neg;
    logic [9:0]              data_q, q_next;

    // diff is N1-N0; the sign tests use the counter MSB so no unsigned promotion creeps in.
    always_comb begin
        n1_s     = CNT_W'(n1);
        n0_s     = CNT_W'(4'd8 - n1);
        diff     = n1_s - n0_s;
        qm8_two  = q_m[8] ? TWO : ZERO;
        nqm8_two = q_m[8] ? ZERO : TWO;
        cnt_neg  = cnt[CNT_W-1];
        cnt_pos  = !cnt[CNT_W-1] && (cnt != ZERO);
        if (cnt == ZERO || n1 == 4'd4) begin
            data_q   = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            data_cnt = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if ((cnt_pos && n1 > 4'd4) || (cnt_neg && n1 < 4'd4)) begin
            data_q   = {1'b1, q_m[8], ~q_m[7:0]};
            data_cnt = cnt - diff + qm8_two;
        end else begin
            data_q   = {1'b0, q_m[8], q_m[7:0]};
            data_cnt = cnt + diff - nqm8_two;
        end
    end

    // Every non-data symbol leaves the disparity counter at zero.
    always_comb begin
        q_next   = ctrl_token(s1.c);
        cnt_next = ZERO;
`ifdef TMDS_TERC4_EN
        if (s1.guard) begin
            q_next = (CHANNEL == 1) ? GB_VID_1 : GB_VID_0;
        end else if (s1.de) begin
            q_next   = data_q;
            cnt_next = data_cnt;
        end else if (s1.aux_en) begin
            q_next = terc4(s1.aux);
        end
`else
        if (s1.de) begin
            q_next   = data_q;
            cnt_next = data_cnt;
        end
`endif
    end

`ifndef TMDS_TERC4_EN
    logic unused_terc4;
    assign unused_terc4 = ^{s1.aux_en, s1.aux, s1.guard, CHANNEL != 0};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q   <= CTRL_00;
            cnt <= ZERO;
        end else begin
            Q   <= q_next;
            cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed token/disparity cases, randomized data
// against a running-disparity model, reference decode of every data symbol, and mid-stream reset.
`timescale 1ns/1ps
module tb_tmds_encoder;

    localparam int CHANNEL = 1;
`ifdef TMDS_TERC4_EN
    localparam bit TERC4 = 1'b1;
`else
    localparam bit TERC4 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       de = 1'b0;
    logic [7:0] d = '0;
    logic [1:0] c = '0;
    logic       aux_en = 1'b0;
    logic [3:0] aux = '0;
    logic       guard = 1'b0;
    logic [9:0] q;

    always #5 clk = ~clk;

    tmds_encoder #(.CHANNEL(CHANNEL), .CNT_W(5)) dut (
        .CLK(clk), .RST(rst), .DE(de), .D(d), .C(c),
        .AUX_EN(aux_en), .AUX(aux), .GUARD(guard), .Q(q)
    );

    logic [9:0] ctrl_lut  [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] terc4_lut [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct {
        bit         valid;
        bit         is_data;
        logic [7:0] d;
        logic [9:0] q;
        int         cnt;
        bit         lit;
        logic [9:0] lit_q;
        int         lit_cnt;
    } exp_t;

    exp_t in_exp, s1_exp, s2_exp, rst_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, req, req);
        end
    endtask

    // Reference model: running disparity is the ones-minus-zeros balance of every data symbol sent.
    task automatic model_step(input bit de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                              input bit aux_en_i, input logic [3:0] aux_i, input bit guard_i,
                              output logic [9:0] sym, output bit is_data);
        logic [7:0] qm;
        bit         xn, qm8, inv;
        int         bal;
        is_data = 1'b0;
        if (TERC4 && guard_i) begin
            sym = (CHANNEL == 1) ? 10'h133 : 10'h2CC;
            model_cnt = 0;
        end else if (de_i) begin
            xn = ($countones(d_i) > 4) || ($countones(d_i) == 4 && !d_i[0]);
            qm[0] = d_i[0];
            for (int i = 1; i < 8; i++)
                qm[i] = xn ? ~(qm[i-1] ^ d_i[i]) : (qm[i-1] ^ d_i[i]);
            qm8 = !xn;
            bal = 2 * $countones(qm) - 8;
            if (model_cnt == 0 || bal == 0) inv = !qm8;
            else                            inv = ((model_cnt > 0) == (bal > 0));
            sym = {inv, qm8, inv ? ~qm : qm};
            model_cnt += 2 * $countones(sym) - 10;
            is_data = 1'b1;
        end else if (TERC4 && aux_en_i) begin
            sym = terc4_lut[aux_i];
            model_cnt = 0;
        end else begin
            sym = ctrl_lut[c_i];
            model_cnt = 0;
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] v, r;
        v = s[9] ? ~s[7:0] : s[7:0];
        r[0] = v[0];
        for (int i = 1; i < 8; i++)
            r[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return r;
    endfunction

    task automatic drive(input bit de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                         input bit aux_en_i, input logic [3:0] aux_i, input bit guard_i,
                         input bit lit = 1'b0, input logic [9:0] lq = '0, input int lc = 0);
        logic [9:0] sym;
        bit         dat;
        @(negedge clk);
        de = de_i; d = d_i; c = c_i; aux_en = aux_en_i; aux = aux_i; guard = guard_i;
        model_step(de_i, d_i, c_i, aux_en_i, aux_i, guard_i, sym, dat);
        in_exp = '{valid: 1'b1, is_data: dat, d: d_i, q: sym, cnt: model_cnt,
                   lit: lit, lit_q: lq, lit_cnt: lc};
        if (lit) begin
            check("model_pin_q", sym, lq);
            check("model_pin_cnt", model_cnt, lc);
        end
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0);
    endtask

    // Two-cycle latency line; a reset pre-loads it with the reset token the DUT must show.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_exp <= rst_exp;
            s2_exp <= rst_exp;
        end else begin
            s1_exp <= in_exp;
            s2_exp <= s1_exp;
        end
    end

    initial begin
        logic signed [31:0] dc;
        forever begin
            @(negedge clk);
            if (s2_exp.valid) begin
                dc = dut.cnt;
                check("q", q, s2_exp.q);
                check("cnt", dc, s2_exp.cnt);
                check("cnt_bound", (dc <= 10 && dc >= -10), 1);
                if (s2_exp.lit) begin
                    check("lit_q", q, s2_exp.lit_q);
                    check("lit_cnt", dc, s2_exp.lit_cnt);
                end
                if (s2_exp.is_data)
                    check("decode", decode(q), s2_exp.d);
            end
        end
    end

    task automatic reset_now();
        rst = 1'b1;
        model_cnt = 0;
        #1;
        check("rst_q_async", q, 10'h354);
        check("rst_cnt", dut.cnt, 0);
        idle();
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst_exp = '{valid: 1'b1, is_data: 1'b0, d: 8'h00, q: 10'h354, cnt: 0,
                    lit: 1'b1, lit_q: 10'h354, lit_cnt: 0};
        #1;
        reset_now();

        drive(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 10'h354, 0);
        drive(1'b0, 8'h00, 2'b01, 1'b0, 4'h0, 1'b0, 1'b1, 10'h0AB, 0);
        drive(1'b0, 8'h00, 2'b10, 1'b0, 4'h0, 1'b0, 1'b1, 10'h154, 0);
        drive(1'b0, 8'h00, 2'b11, 1'b0, 4'h0, 1'b0, 1'b1, 10'h2AB, 0);
        drive(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 10'h100, -8);
        drive(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 10'h3FF, 2);
        drive(1'b1, 8'h00, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 10'h100, -6);
        idle();
        drive(1'b1, 8'hFF, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 10'h200, -8);

`ifdef TMDS_TERC4_EN
        drive(1'b0, 8'h00, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 10'h133, 0);
        drive(1'b0, 8'h00, 2'b00, 1'b1, 4'h0, 1'b0, 1'b1, 10'h29C, 0);
        drive(1'b1, 8'h5A, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 10'h133, 0);
        drive(1'b1, 8'h3C, 2'b00, 1'b1, 4'h0, 1'b1, 1'b1, 10'h133, 0);
        drive(1'b1, 8'h00, 2'b00, 1'b1, 4'h0, 1'b0, 1'b1, 10'h100, -8);
`else
        drive(1'b0, 8'h00, 2'b10, 1'b1, 4'h0, 1'b1);
        drive(1'b1, 8'h00, 2'b00, 1'b1, 4'h0, 1'b1);
`endif

        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 15) != 0, 8'($urandom), 2'($urandom),
                  1'($urandom), 4'($urandom), $urandom_range(0, 31) == 0);

        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'($urandom), 2'b00, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #3;
        reset_now();
        for (int i = 0; i < 200; i++)
            drive(1'b1, 8'($urandom), 2'b00, 1'b0, 4'h0, 1'b0);

        idle();
        idle();
        idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
